// File: rtl/sha256_pkg.sv
// Shared constants and the state encoding for the SHA-256 message padder.
package sha256_pkg;

    localparam int unsigned BLOCK_W         = 512;
    localparam logic [7:0]  PAD_MARKER      = 8'h80;
    localparam int unsigned LEN_FIELD_BYTES = 8;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_LEN  = 2'd2,
        S_EMIT = 2'd3
    } pad_state_t;

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks, appends
// the 0x80 marker, zero fill and the 64-bit big-endian bit length, and hands
// blocks to the core sequencer with first/last flags.
// Optional feature: define SHA256_PAD_OVF_EN to get the sticky len_ovf output.
//
// state | meaning
// FILL  | accepting message bytes into the block buffer
// PAD   | writing marker / zero bytes, one per cycle
// LEN   | writing the length field into bytes 56..63
// EMIT  | block presented on blk_data, waiting for blk_ready
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic               blk_first,
    output logic               blk_last
`ifdef SHA256_PAD_OVF_EN
    ,
    output logic               len_ovf
`endif
);

    localparam logic [5:0] LAST_IDX = 6'd63;
    localparam logic [5:0] LAST_PAD_IDX = 6'(63 - LEN_FIELD_BYTES);

    pad_state_t       state;
    pad_state_t       resume;
    logic [5:0]       idx;
    logic [LEN_W-1:0] bitlen;
    logic             marker_done;
    logic             final_blk;
    logic             first_blk;
    logic [7:0]       pad_byte;

    // Bytes are only taken while filling; everything else back-pressures.
    assign in_ready  = (state == S_FILL);
    assign blk_first = first_blk;
    assign blk_last  = final_blk;
    assign pad_byte  = marker_done ? 8'h00 : PAD_MARKER;

`ifdef SHA256_PAD_OVF_EN
    // bitlen is always a multiple of 8, so adding 8 wraps exactly when all upper bits are set.
    logic ovf_carry;
    assign ovf_carry = &bitlen[LEN_W-1:3];
`endif

    // Padder FSM; the output register doubles as the block buffer, byte i at bits {~i,3'b111} -: 8.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FILL;
            resume      <= S_FILL;
            idx         <= '0;
            bitlen      <= '0;
            marker_done <= 1'b0;
            final_blk   <= 1'b0;
            first_blk   <= 1'b1;
            blk_valid   <= 1'b0;
            blk_data    <= '0;
`ifdef SHA256_PAD_OVF_EN
            len_ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                S_FILL: begin
                    if (in_valid) begin
                        blk_data[{~idx, 3'b111} -: 8] <= in_data;
                        bitlen <= bitlen + LEN_W'(8);
                        idx    <= idx + 6'd1;
`ifdef SHA256_PAD_OVF_EN
                        if (ovf_carry) len_ovf <= 1'b1;
`endif
                        if (idx == LAST_IDX) begin
                            state       <= S_EMIT;
                            blk_valid   <= 1'b1;
                            final_blk   <= 1'b0;
                            marker_done <= 1'b0;
                            resume      <= in_last ? S_PAD : S_FILL;
                        end else if (in_last) begin
                            state       <= S_PAD;
                            marker_done <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    blk_data[{~idx, 3'b111} -: 8] <= pad_byte;
                    marker_done <= 1'b1;
                    idx         <= idx + 6'd1;
                    if (idx == LAST_PAD_IDX) begin
                        state <= S_LEN;
                    end else if (idx == LAST_IDX) begin
                        state     <= S_EMIT;
                        blk_valid <= 1'b1;
                        final_blk <= 1'b0;
                        resume    <= S_PAD;
                    end
                end
                S_LEN: begin
                    blk_data[LEN_FIELD_BYTES*8-1:0] <= (LEN_FIELD_BYTES*8)'(bitlen);
                    state     <= S_EMIT;
                    blk_valid <= 1'b1;
                    final_blk <= 1'b1;
                end
                S_EMIT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        idx       <= '0;
                        first_blk <= 1'b0;
                        if (final_blk) begin
                            state     <= S_FILL;
                            first_blk <= 1'b1;
                            final_blk <= 1'b0;
                            bitlen    <= '0;
`ifdef SHA256_PAD_OVF_EN
                            len_ovf   <= 1'b0;
`endif
                        end else begin
                            state <= resume;
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder with a block scoreboard fed by an
// independent FIPS 180-4 padding model.
module tb_sha256_padder;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    logic         clk;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;
`ifdef SHA256_PAD_OVF_EN
    logic         len_ovf;
`endif

    blk_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    sha256_padder #(.LEN_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
`ifdef SHA256_PAD_OVF_EN
        ,
        .len_ovf   (len_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic byte_q_t make_msg(input int n, input int seed);
        byte_q_t m;
        for (int i = 0; i < n; i++) m.push_back(8'((i * 7 + seed) & 8'hff));
        return m;
    endfunction

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic push_expected(input byte_q_t msg);
        byte_q_t      p;
        logic [63:0]  bits;
        blk_t         b;
        int           nblk;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < 64; j++) b.data[511 - 8*j -: 8] = p[64*k + j];
            b.first = (k == 0);
            b.last  = (k == nblk - 1);
            sb.push_back(b);
        end
    endtask

    // Streams one message and consumes its blocks; latencies are counted in
    // cycles from the last byte accept to the cycle blk_valid is first seen.
    task automatic run_msg(input byte_q_t msg, input int stall, input bit gaps,
                           input int lat_blk0, input int lat_final);
        int   idx = 0;
        int   n;
        int   blk_n = 0;
        int   last_acc = 0;
        bit   done = 0;
        blk_t e;
        logic [511:0] hold;
        n = msg.size();
        push_expected(msg);
        for (int t = 0; t < 1500 && !done; t++) begin
            @(negedge clk);
            cyc++;
            if (blk_valid) begin
                if (blk_n == 0 && lat_blk0 >= 0) chk("lat_blk0", 512'(cyc - last_acc), 512'(lat_blk0));
                if (sb.size() == 1 && lat_final >= 0) chk("lat_final", 512'(cyc - last_acc), 512'(lat_final));
                if (blk_n == 0 && stall > 0) begin
                    blk_ready = 1'b0;
                    hold = blk_data;
                    for (int s = 0; s < stall; s++) begin
                        @(negedge clk);
                        cyc++;
                        chk("stall_data", blk_data, hold);
                        chk("stall_in_ready", 512'(in_ready), 512'(0));
                        chk("stall_valid", 512'(blk_valid), 512'(1));
                    end
                end
                blk_ready = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_block", 512'(blk_valid), 512'(0));
                end else begin
                    e = sb.pop_front();
                    chk("blk_data", blk_data, e.data);
                    chk("blk_first", 512'(blk_first), 512'(e.first));
                    chk("blk_last", 512'(blk_last), 512'(e.last));
                end
                blk_n++;
            end
            in_valid = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
            in_data  = (idx < n) ? msg[idx] : 8'h00;
            in_last  = (idx == n - 1);
            if (in_valid && in_ready) begin
                idx++;
                last_acc = cyc;
            end
            done = (idx == n) && (sb.size() == 0) && !in_valid;
        end
        if (!done) chk("timeout", 512'(0), 512'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        cyc++;
`ifdef SHA256_PAD_OVF_EN
        chk("len_ovf", 512'(len_ovf), 512'(0));
`endif
    endtask

    initial begin
        byte_q_t abc;
        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_blk_valid", 512'(blk_valid), 512'(0));
        chk("rst_blk_first", 512'(blk_first), 512'(1));
        chk("rst_blk_last", 512'(blk_last), 512'(0));
        chk("rst_blk_data", blk_data, 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(1));
`ifdef SHA256_PAD_OVF_EN
        chk("rst_len_ovf", 512'(len_ovf), 512'(0));
`endif

        abc = '{8'h61, 8'h62, 8'h63};
        run_msg(abc, 0, 0, -1, 55);

        // Spot-check the "abc" block against known constants, independent of the model.
        push_expected(abc);
        chk("abc_word0", 512'(sb[0].data[511:480]), 512'(32'h61626380));
        chk("abc_len", 512'(sb[0].data[31:0]), 512'(32'h00000018));
        sb.delete();

        run_msg(make_msg(55, 3), 0, 0, -1, 3);
        run_msg(make_msg(56, 5), 0, 0, -1, -1);
        run_msg(make_msg(64, 9), 0, 0, 1, -1);
        run_msg(make_msg(70, 11), 20, 0, -1, -1);
        run_msg(make_msg(130, 13), 0, 1, -1, -1);

        // Reset in the middle of padding discards the partial message.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = abc[i];
            in_last  = (i == 2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_pad_in_ready", 512'(in_ready), 512'(0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mpr_blk_valid", 512'(blk_valid), 512'(0));
        chk("mpr_blk_first", 512'(blk_first), 512'(1));
        chk("mpr_in_ready", 512'(in_ready), 512'(1));
        run_msg(abc, 0, 0, -1, 55);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
